// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier:
// control-state encoding and the Booth recoding of the multiplier bit pair.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        EVAL  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        NOP = 2'b00,
        ADD = 2'b01,
        SUB = 2'b10
    } booth_op_t;

    // Radix-2 Booth recoding of {Q[0], q_1}: 01 adds M, 10 subtracts M.
    function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
        booth_op_t op;
        case ({q0, q_1})
            2'b01:   op = ADD;
            2'b10:   op = SUB;
            default: op = NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_ctrl_fsm.sv
// Control unit for the Booth multiplier: state register, iteration counter
// and the strobes that sequence the A/Q/M datapath.
module booth_ctrl_fsm
    import booth_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] booth_bits,
    output logic       load,
    output logic       eval_add,
    output logic       eval_sub,
    output logic       shift,
    output logic       fin,
    output logic       busy
);

    localparam logic [CNT_W-1:0] ITERS = CNT_W'(WIDTH + 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    booth_op_t        op;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // NOTE: every output and next-state signal gets a default first, so no
    // path through the case statement can leave one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        load     = 1'b0;
        eval_add = 1'b0;
        eval_sub = 1'b0;
        shift    = 1'b0;
        fin      = 1'b0;
        op       = booth_decode(booth_bits[1], booth_bits[0]);

        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    count_d = ITERS;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                eval_add = (op == ADD);
                eval_sub = (op == SUB);
                state_d  = SHIFT;
            end
            SHIFT: begin
                shift   = 1'b1;
                count_d = count_q - ONE;
                state_d = (count_q == ONE) ? DONE : EVAL;
            end
            DONE: begin
                fin     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy = (state_q == EVAL) || (state_q == SHIFT);
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with start/busy/done handshake and
// per-operation signed/unsigned mode; holds the A/Q/M/q_1/product datapath.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // One guard bit lets unsigned operands run through the signed algorithm.
    localparam int E = WIDTH + 1;

    logic [E-1:0]       a, q, m;
    logic               q_1;
    logic [E-1:0]       m_ext, q_ext;
    logic               load, eval_add, eval_sub, shift, fin;

    assign m_ext = {sgn & multiplicand[WIDTH-1], multiplicand};
    assign q_ext = {sgn & multiplier[WIDTH-1], multiplier};

    booth_ctrl_fsm #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .booth_bits ({q[0], q_1}),
        .load       (load),
        .eval_add   (eval_add),
        .eval_sub   (eval_sub),
        .shift      (shift),
        .fin        (fin),
        .busy       (busy)
    );

    // NOTE: all datapath registers are reset, because an abort must clear
    // product and leave no stale operand state behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a       <= '0;
            q       <= '0;
            m       <= '0;
            q_1     <= 1'b0;
            product <= '0;
        end else begin
            if (load) begin
                a   <= '0;
                q   <= q_ext;
                m   <= m_ext;
                q_1 <= 1'b0;
            end else if (eval_add) begin
                a <= a + m;
            end else if (eval_sub) begin
                a <= a - m;
            end else if (shift) begin
                {a, q, q_1} <= {a[E-1], a, q};
            end

            // Low 2*WIDTH bits of the 2*E-bit {A,Q} hold the exact product.
            if (fin) begin
                product <= {a[WIDTH-2:0], q};
            end
        end
    end

    assign done = fin;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq: 8-bit vectors, handshake timing,
// start/reset boundary cases and an exhaustive 4-bit sweep.
module tb_booth_mult_seq;

    logic        clk;
    logic        reset;

    logic        start8, sgn8, busy8, done8;
    logic [7:0]  mc8, mp8;
    logic [15:0] product8;

    logic        start4, sgn4, busy4, done4;
    logic [3:0]  mc4, mp4;
    logic [7:0]  product4;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clk          (clk),
        .reset        (reset),
        .start        (start8),
        .sgn          (sgn8),
        .multiplicand (mc8),
        .multiplier   (mp8),
        .busy         (busy8),
        .done         (done8),
        .product      (product8)
    );

    booth_mult_seq #(.WIDTH(4)) dut4 (
        .clk          (clk),
        .reset        (reset),
        .start        (start4),
        .sgn          (sgn4),
        .multiplicand (mc4),
        .multiplier   (mp4),
        .busy         (busy4),
        .done         (done4),
        .product      (product4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Drive a start pulse; returns at the negedge right after the accepting edge.
    task automatic start8_op(input logic s, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        sgn8 = s; mc8 = a; mp8 = b; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    // Counts edges after the accepting edge until done; optionally injects a
    // spurious start pulse with different operands at edge inject_at.
    task automatic wait8(input int inject_at, output int lat, output int busy_bad);
        lat = -1;
        busy_bad = 0;
        for (int j = 0; j < 100; j++) begin
            if (done8) begin
                lat = j;
                break;
            end
            if (!busy8) busy_bad++;
            if (j == inject_at) begin
                start8 = 1'b1; sgn8 = ~sgn8; mc8 = 8'h55; mp8 = 8'h02;
            end else if (j == inject_at + 1) begin
                start8 = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic run8(input string tag, input logic s, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp, input int inject_at);
        int lat, busy_bad;
        start8_op(s, a, b);
        wait8(inject_at, lat, busy_bad);
        check({tag, " latency"}, lat, 18);
        check({tag, " busy"}, busy_bad, 0);
        check({tag, " busy at done"}, {31'd0, busy8}, 0);
        @(negedge clk);
        check({tag, " done width"}, {31'd0, done8}, 0);
        check({tag, " product"}, {16'd0, product8}, {16'd0, exp});
    endtask

    task automatic run4(input logic s, input logic [3:0] a, input logic [3:0] b);
        int av, bv, lat;
        logic [7:0] exp;
        av = (s && a[3]) ? int'(a) - 16 : int'(a);
        bv = (s && b[3]) ? int'(b) - 16 : int'(b);
        exp = 8'(av * bv);
        @(negedge clk);
        sgn4 = s; mc4 = a; mp4 = b; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        lat = -1;
        for (int j = 0; j < 40; j++) begin
            if (done4) begin
                lat = j;
                break;
            end
            @(negedge clk);
        end
        check($sformatf("w4 s%0d %0d*%0d latency", s, a, b), lat, 10);
        @(negedge clk);
        check($sformatf("w4 s%0d %0d*%0d done width", s, a, b), {31'd0, done4}, 0);
        check($sformatf("w4 s%0d %0d*%0d product", s, a, b), {24'd0, product4}, {24'd0, exp});
    endtask

    initial begin
        int lat, busy_bad, t_first, t_second, done_seen;

        reset = 1'b0;
        start8 = 1'b0; sgn8 = 1'b0; mc8 = '0; mp8 = '0;
        start4 = 1'b0; sgn4 = 1'b0; mc4 = '0; mp4 = '0;
        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, busy8}, 0);
        check("reset done", {31'd0, done8}, 0);
        check("reset product", {16'd0, product8}, 0);
        check("reset product4", {24'd0, product4}, 0);
        reset = 1'b1;

        // Product is not updated until the edge after done.
        start8_op(1'b1, 8'd3, 8'hFC);
        wait8(-1, lat, busy_bad);
        check("3x-4 latency", lat, 18);
        check("3x-4 busy", busy_bad, 0);
        check("3x-4 product held at done", {16'd0, product8}, 0);
        @(negedge clk);
        check("3x-4 done width", {31'd0, done8}, 0);
        check("3x-4 product", {16'd0, product8}, 32'h0000FFF4);

        run8("u255x255", 1'b0, 8'hFF, 8'hFF, 16'hFE01, -1);
        run8("s-1x-1",   1'b1, 8'hFF, 8'hFF, 16'h0001, -1);
        run8("s-128x-128", 1'b1, 8'h80, 8'h80, 16'h4000, -1);
        run8("s-128x127",  1'b1, 8'h80, 8'h7F, 16'hC080, -1);
        run8("u7x9 with mid start", 1'b0, 8'd7, 8'd9, 16'h003F, 5);

        // Start held high: back-to-back results every 2*WIDTH+4 cycles.
        @(negedge clk);
        sgn8 = 1'b0; mc8 = 8'd10; mp8 = 8'd12; start8 = 1'b1;
        t_first = -1;
        t_second = -1;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (done8) begin
                if (t_first < 0) begin
                    t_first = cyc;
                end else begin
                    t_second = cyc;
                    start8 = 1'b0;
                    break;
                end
            end
        end
        check("held start spacing", t_second - t_first, 20);
        @(negedge clk);
        check("held start product", {16'd0, product8}, 32'h00000078);

        // Reset mid-operation.
        start8_op(1'b0, 8'd5, 8'd6);
        repeat (7) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort busy", {31'd0, busy8}, 0);
        check("abort done", {31'd0, done8}, 0);
        check("abort product", {16'd0, product8}, 0);
        @(negedge clk);
        reset = 1'b1;
        done_seen = 0;
        for (int j = 0; j < 25; j++) begin
            @(negedge clk);
            if (done8) done_seen++;
        end
        check("abort no done pulse", done_seen, 0);
        run8("u5x6 after abort", 1'b0, 8'd5, 8'd6, 16'h001E, -1);

        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    run4(1'(s), 4'(a), 4'(b));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Parametrised sequential radix-2 Booth multiplier: control FSM plus A/Q/M datapath, successor to the fixed 3-bit Booth control unit.
- Adds generic operand width and an iteration counter in place of one state per step.
- Adds a start/busy/done handshake and a signed/unsigned mode selected per operation.
- Sits in the booth/ arithmetic area and is used standalone or as the multiply unit behind the CPU ALU.

Parameters:
WIDTH, 8, operand width in bits (>=2); product is 2*WIDTH bits.
CNT_W, $clog2(WIDTH+2), iteration counter width (derived; do not override).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset (0 = reset).
start  input  1  request; sampled only in IDLE.
sgn  input  1  1 = signed two's-complement operands, 0 = unsigned; sampled with start.
multiplicand  input  WIDTH  M operand; sampled with start.
multiplier  input  WIDTH  Q operand; sampled with start.
busy  output  1  high in EVAL and SHIFT.
done  output  1  one-cycle pulse; product valid.
product  output  2*WIDTH  result; held from done until the next accepted start.

Behaviour:
- Reset (async, reset=0): state=IDLE; A, Q, M, q_1, count, product = 0; busy=0; done=0.
- Internal width is E=WIDTH+1. M, A and Q are E bits each.
  - sgn=1: operands are sign-extended to E bits.
  - sgn=0: operands are zero-extended to E bits.
  - The algorithm then always runs E iterations of signed Booth.
- FSM states: IDLE, EVAL, SHIFT, DONE.
- IDLE:
  - start=0: stay in IDLE.
  - start=1: on the edge, M <= ext(multiplicand), Q <= ext(multiplier), A <= 0, q_1 <= 0, count <= E; go to EVAL.
- EVAL, using {Q[0], q_1}:
  - 01: A <= A+M.
  - 10: A <= A-M.
  - 00 or 11: A unchanged.
  - A is E bits and wraps modulo 2^E. Then go to SHIFT.
- SHIFT:
  - {A,Q,q_1} <= arithmetic right shift by 1; A[E-1] is replicated.
  - count <= count-1.
  - If count==1, go to DONE; otherwise go to EVAL.
- DONE:
  - product <= lower 2*WIDTH bits of {A,Q}.
  - done=1 for exactly this one cycle; go to IDLE.
- Outputs are registered or state-decoded only. No combinational path from any input to any output.
- Latency: with the start-sampling edge as edge 0, the state is DONE after edge 2*E = 2*WIDTH+2. done is high during that cycle.
  - product holds the result from the edge after that, then stays stable in IDLE.
  - Throughput: one result per 2*WIDTH+4 cycles, counting the IDLE cycle needed to accept the next start.
- Boundary conditions:
  - start while busy or in DONE: ignored. Operands and mode are not re-sampled.
  - start=1 held continuously: a new operation is accepted on the first IDLE cycle after DONE.
  - product is not cleared on start. It changes only in DONE or on reset.
  - Reset mid-operation: immediate abort to IDLE, all registers and outputs cleared. No done pulse.
  - Extreme operands fit without overflow: signed (-2^(W-1))^2 and unsigned (2^W-1)^2 both fit in 2*WIDTH bits.

Decomposition:
- Package booth_pkg holds:
  - the state encoding (IDLE=2'b00, EVAL=2'b01, SHIFT=2'b10, DONE=2'b11);
  - the Booth op decode constants (NOP, ADD, SUB).
- One sub-module, booth_ctrl_fsm:
  - contains the state register, iteration counter and next-state logic;
  - outputs load, eval_add, eval_sub, shift, fin and busy strobes.
- The top level holds the A/Q/M/q_1/product datapath.

Test Plan:
- WIDTH=8, sgn=1, 3 x -4 -> product=16'hFFF4. done rises exactly 18 cycles after the start edge; busy is high for cycles 1..18-1.
- WIDTH=8, sgn=0, 255 x 255 -> 16'hFE01. Repeat with sgn=1 (-1 x -1) -> 16'h0001.
- WIDTH=8, sgn=1, -128 x -128 -> 16'h4000. Also -128 x 127 -> 16'hC080.
- Pulse start with new operands mid-operation (cycle 5) -> ignored; result is the first operation's. With start held high continuously, back-to-back results are spaced 20 cycles apart.
- Drive reset=0 at cycle 7 of an operation -> busy, done and product are 0 immediately. With no done pulse, the next start yields a correct fresh result.
- WIDTH=4: exhaustive 16x16 for both sgn values against a reference model; done is exactly one cycle wide every time.
